// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit mini CPU control path: data and
// register-select widths, instruction field positions, opcode and FSM state
// encodings, and a helper that classifies ALU opcodes.
// Ports: none (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 4;
    localparam int REG_W  = 2;

    // Instruction field bit positions for the 10-bit instruction word.
    localparam int OPC_MSB = 9;
    localparam int OPC_LSB = 7;
    localparam int RD_MSB  = 6;
    localparam int RD_LSB  = 5;
    localparam int RS1_MSB = 4;
    localparam int RS1_LSB = 3;
    localparam int RS2_MSB = 2;
    localparam int RS2_LSB = 1;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_LDI  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    // True for the opcodes whose result comes from the ALU and updates flags.
    function automatic logic is_alu_op(opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// ----------------------------------------------------------------------------
// cpu_control_unit_if
// Bus between the control unit and its memories: the combinational
// instruction ROM port and the register file's two read ports and one
// synchronous write port.
// master: control unit (drives addresses, selects, write data/enable).
// slave : ROM + register file (drives instruction and read data).
// ----------------------------------------------------------------------------
interface cpu_control_unit_if
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 4,
    parameter int INSTR_W = 10
);

    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [REG_W-1:0]   read_reg1;
    logic [REG_W-1:0]   read_reg2;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [REG_W-1:0]   write_reg;
    logic [DATA_W-1:0]  write_data;
    logic               reg_write;

    modport master (
        output imem_addr, read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  imem_data, read_data1, read_data2
    );

    modport slave (
        input  imem_addr, read_reg1, read_reg2, write_reg, write_data, reg_write,
        output imem_data, read_data1, read_data2
    );

endinterface

// File: rtl/cpu_control_unit_alu.sv
// ----------------------------------------------------------------------------
// cpu_alu
// Combinational 4-bit ALU for the mini CPU.
// Inputs : op (opcode), a, b (operands).
// Outputs: y (result mod 16), carry (ADD carry-out / SUB borrow, 0 for logic
//          ops), zero (y == 0).
// ----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// ----------------------------------------------------------------------------
// cpu_control_unit
// Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit mini CPU.
// Owns the PC, instruction register, operand/result registers and ALU flags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin execution at PC 0 (only in IDLE/HALTED)
//   bus (master)        instruction ROM and register-file ports
//   pc                  program counter (also drives bus.imem_addr)
//   busy, halted        state decodes
//   flag_zero/carry     ALU flags from the last ALU instruction
// ----------------------------------------------------------------------------
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 4,
    parameter int INSTR_W = 10
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    cpu_control_unit_if.master bus,
    output logic [IMEM_AW-1:0] pc,
    output logic               busy,
    output logic               halted,
    output logic               flag_zero,
    output logic               flag_carry
);

    state_t             state, next_state;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  opa, opb, result;
    logic [REG_W-1:0]   write_reg_q;
    opcode_t            opcode;
    logic [DATA_W-1:0]  alu_y, exec_value;
    logic               alu_carry, alu_zero;
    logic               load_ir, load_ops, load_result, pc_clear, pc_inc;

    assign opcode     = opcode_t'(ir[OPC_MSB:OPC_LSB]);
    assign exec_value = (opcode == OP_LDI) ? ir[IMM_MSB:IMM_LSB] : alu_y;

    cpu_alu u_alu (
        .op    (opcode),
        .a     (opa),
        .b     (opb),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Everything visible outside comes from registers or the state decode,
    // so no output path runs combinationally from imem_data or read_data*.
    assign bus.imem_addr  = pc;
    assign bus.read_reg1  = ir[RS1_MSB:RS1_LSB];
    assign bus.read_reg2  = ir[RS2_MSB:RS2_LSB];
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = result;
    assign bus.reg_write  = (state == ST_WRITEBACK);
    assign busy   = (state == ST_FETCH) || (state == ST_DECODE) ||
                    (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign halted = (state == ST_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load_ir     = 1'b0;
        load_ops    = 1'b0;
        load_result = 1'b0;
        pc_clear    = 1'b0;
        pc_inc      = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    pc_clear   = 1'b1;
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                load_ir    = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                load_ops   = 1'b1;
                next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (opcode)
                    OP_NOP: begin
                        pc_inc     = 1'b1;
                        next_state = ST_FETCH;
                    end
                    OP_HALT: next_state = ST_HALTED;
                    default: begin
                        load_result = 1'b1;
                        next_state  = ST_WRITEBACK;
                    end
                endcase
            end
            ST_WRITEBACK: begin
                pc_inc     = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // write_reg and result only change on entry to WRITEBACK, so the write
    // port holds the last written target and data in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            opa         <= '0;
            opb         <= '0;
            result      <= '0;
            write_reg_q <= '0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
        end else begin
            if (pc_clear) begin
                pc <= '0;
            end else if (pc_inc) begin
                pc <= pc + 1'b1;
            end
            if (load_ir) begin
                ir <= bus.imem_data;
            end
            if (load_ops) begin
                opa <= bus.read_data1;
                opb <= bus.read_data2;
            end
            if (load_result) begin
                result      <= exec_value;
                write_reg_q <= ir[RD_MSB:RD_LSB];
                if (is_alu_op(opcode)) begin
                    flag_zero  <= alu_zero;
                    flag_carry <= alu_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// ----------------------------------------------------------------------------
// tb_cpu_control_unit
// Self-checking bench for cpu_control_unit. Models the instruction ROM and
// the 4x4-bit register file, pushes expected register writes into a
// scoreboard queue and compares them as reg_write pulses appear.
// ----------------------------------------------------------------------------
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] pc;
    logic       busy, halted, flag_zero, flag_carry;

    cpu_control_unit_if #(.IMEM_AW(4), .INSTR_W(10)) bus ();

    cpu_control_unit #(.IMEM_AW(4), .INSTR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    always #5 clk = ~clk;

    logic [9:0] rom [0:15];
    logic [3:0] regs [0:3] = '{4'd0, 4'd0, 4'd0, 4'd0};
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         start_cyc;
    bit         monitor_on = 1'b1;
    logic [5:0] expected_q [$];
    int         write_cycles [$];

    assign bus.imem_data  = rom[bus.imem_addr];
    assign bus.read_data1 = regs[bus.read_reg1];
    assign bus.read_data2 = regs[bus.read_reg2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.reg_write) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer: each write pulse must match the next expected write.
    always @(negedge clk) begin
        if (monitor_on && bus.reg_write === 1'b1) begin
            write_cycles.push_back(cyc);
            if (expected_q.size() == 0) begin
                checkOutput("unexpected_write", {26'd0, bus.write_reg, bus.write_data}, 32'hFFFF);
            end else begin
                checkOutput("write", {26'd0, bus.write_reg, bus.write_data},
                            {26'd0, expected_q.pop_front()});
            end
        end
    end

    function automatic logic [9:0] enc_r(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 1'b0};
    endfunction

    function automatic logic [9:0] enc_ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b110, rd, 1'b0, imm};
    endfunction

    localparam logic [9:0] I_NOP  = 10'b000_0000000;
    localparam logic [9:0] I_HALT = 10'b111_0000000;

    task automatic clearRom();
        for (int i = 0; i < 16; i++) rom[i] = I_NOP;
    endtask

    // Pulse start for one edge; afterwards we sit in the first FETCH cycle.
    task automatic applyStimulus();
        write_cycles.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        checkOutput("start_pc", pc, 0);
        checkOutput("start_busy", busy, 1);
    endtask

    task automatic waitHalted(input int max_cycles);
        int n = 0;
        while (halted !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt_reached", halted, 1);
        checkOutput("sb_empty", expected_q.size(), 0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clearRom();
        repeat (3) @(negedge clk);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_reg_write", bus.reg_write, 0);
        checkOutput("rst_flags", {flag_zero, flag_carry}, 0);
        checkOutput("rst_wr", {bus.write_reg, bus.write_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LDI r1,7; LDI r2,9; ADD r3,r1,r2; HALT
        rom[0] = enc_ldi(2'd1, 4'd7);
        rom[1] = enc_ldi(2'd2, 4'd9);
        rom[2] = enc_r(3'b001, 2'd3, 2'd1, 2'd2);
        rom[3] = I_HALT;
        expected_q.push_back({2'd1, 4'd7});
        expected_q.push_back({2'd2, 4'd9});
        expected_q.push_back({2'd3, 4'd0});
        applyStimulus();
        waitHalted(60);
        checkOutput("t1_pc", pc, 3);
        checkOutput("t1_zero", flag_zero, 1);
        checkOutput("t1_carry", flag_carry, 1);
        checkOutput("t1_r3", regs[3], 0);
        checkOutput("t1_writes", write_cycles.size(), 3);
        if (write_cycles.size() == 3) begin
            checkOutput("t1_first_lat", write_cycles[0] - start_cyc, 3);
            checkOutput("t1_gap1", write_cycles[1] - write_cycles[0], 4);
            checkOutput("t1_gap2", write_cycles[2] - write_cycles[1], 4);
        end

        // SUB with borrow, then SUB to zero after a restart from HALTED
        clearRom();
        rom[0] = enc_ldi(2'd1, 4'd3);
        rom[1] = enc_ldi(2'd2, 4'd5);
        rom[2] = enc_r(3'b010, 2'd0, 2'd1, 2'd2);
        rom[3] = I_HALT;
        expected_q.push_back({2'd1, 4'd3});
        expected_q.push_back({2'd2, 4'd5});
        expected_q.push_back({2'd0, 4'd14});
        applyStimulus();
        waitHalted(60);
        checkOutput("t2_r0", regs[0], 14);
        checkOutput("t2_carry", flag_carry, 1);
        checkOutput("t2_zero", flag_zero, 0);
        clearRom();
        rom[0] = enc_r(3'b010, 2'd0, 2'd1, 2'd1);
        rom[1] = I_HALT;
        expected_q.push_back({2'd0, 4'd0});
        applyStimulus();
        waitHalted(40);
        checkOutput("t2b_pc", pc, 1);
        checkOutput("t2b_r0", regs[0], 0);
        checkOutput("t2b_zero", flag_zero, 1);
        checkOutput("t2b_carry", flag_carry, 0);

        // NOP costs 3 cycles; rerun from HALTED gives the same result
        clearRom();
        rom[0] = I_NOP;
        rom[1] = enc_ldi(2'd2, 4'd6);
        rom[2] = I_HALT;
        for (int run = 0; run < 2; run++) begin
            expected_q.push_back({2'd2, 4'd6});
            applyStimulus();
            waitHalted(40);
            checkOutput("t3_pc", pc, 2);
            checkOutput("t3_r2", regs[2], 6);
            checkOutput("t3_writes", write_cycles.size(), 1);
            if (write_cycles.size() == 1) begin
                checkOutput("t3_lat", write_cycles[0] - start_cyc, 6);
            end
            checkOutput("t3_zero_kept", flag_zero, 1);
        end

        // 17 NOP steps: PC walks 0..15 and wraps to 0
        clearRom();
        applyStimulus();
        for (int i = 0; i <= 16; i++) begin
            checkOutput($sformatf("t4_pc%0d", i), pc, i % 16);
            checkOutput($sformatf("t4_busy%0d", i), busy, 1);
            repeat (3) @(negedge clk);
        end
        checkOutput("t4_writes", write_cycles.size(), 0);
        pulseReset();

        // Reset asserted in WRITEBACK of LDI r2,5 abandons the write
        monitor_on = 1'b0;
        rom[0] = enc_ldi(2'd2, 4'd5);
        applyStimulus();
        repeat (3) @(negedge clk);
        checkOutput("t5_wb_reg_write", bus.reg_write, 1);
        checkOutput("t5_wb_target", {bus.write_reg, bus.write_data}, {2'd2, 4'd5});
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_reg_write", bus.reg_write, 0);
        checkOutput("t5_pc", pc, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_halted", halted, 0);
        checkOutput("t5_flags", {flag_zero, flag_carry}, 0);
        checkOutput("t5_wr", {bus.write_reg, bus.write_data}, 0);
        @(posedge clk);
        #1;
        checkOutput("t5_r2_kept", regs[2], 6);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5_idle_busy", busy, 0);
        checkOutput("t5_r2_final", regs[2], 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
